// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types and constants for the NTT stage sequencer (package ntt_pkg).
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int N_DEF      = 256;
  localparam int Q          = 8380417;
  localparam int BU_LAT_DEF = 3;
  localparam int ADDR_W_DEF = $clog2(N_DEF);

  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Command and memory-side signals of the NTT stage sequencer.
// mode_i / tw_neg_o exist only when NTT_STAGE_CTRL_INTT_EN is defined.
interface ntt_stage_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr1_o;
  logic [ADDR_W-1:0] rd_addr2_o;
  logic [ADDR_W-1:0] tw_addr_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr1_o;
  logic [ADDR_W-1:0] wr_addr2_o;
`ifdef NTT_STAGE_CTRL_INTT_EN
  logic              mode_i;
  logic              tw_neg_o;
`endif

  modport master (
`ifdef NTT_STAGE_CTRL_INTT_EN
    output mode_i,
    input  tw_neg_o,
`endif
    output start_i,
    input  busy_o, done_o, rd_en_o, rd_addr1_o, rd_addr2_o, tw_addr_o,
    input  wr_en_o, wr_addr1_o, wr_addr2_o
  );

  modport slave (
`ifdef NTT_STAGE_CTRL_INTT_EN
    input  mode_i,
    output tw_neg_o,
`endif
    input  start_i,
    output busy_o, done_o, rd_en_o, rd_addr1_o, rd_addr2_o, tw_addr_o,
    output wr_en_o, wr_addr1_o, wr_addr2_o
  );

endinterface

// File: rtl/ntt_stage_ctrl_addr_gen.sv
// Loop counters of the in-place NTT schedule: current butterfly (j, j+len, k)
// plus group/stage boundary flags; inverse ordering with NTT_STAGE_CTRL_INTT_EN.
module ntt_addr_gen #(
  parameter int N      = 256,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
`ifdef NTT_STAGE_CTRL_INTT_EN
  input  logic              inv_i,
  output logic              inv_o,
`endif
  input  logic              step_i,
  input  logic              next_stage_i,
  output logic [ADDR_W-1:0] j_o,
  output logic [ADDR_W-1:0] j2_o,
  output logic [ADDR_W-1:0] k_o,
  output logic              last_in_stage_o,
  output logic              last_stage_o
);
  localparam int LOG_N = $clog2(N);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] j_q, j_d, j2_q, j2_d, start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d, k_q, k_d, stage_q, stage_d;
  logic              last_in_group;

  assign last_in_group   = (j_q == start_q + len_q - ONE);
  assign last_in_stage_o = (j_q == LAST_IDX - len_q);
  assign last_stage_o    = (stage_q == ADDR_W'(LOG_N - 1));
  assign j_o  = j_q;
  assign j2_o = j2_q;
  assign k_o  = k_q;

`ifdef NTT_STAGE_CTRL_INTT_EN
  logic inv_q, inv_d;
  assign inv_o = inv_q;
`endif

  // Next group starts at j+len+1, which avoids forming 2*len (overflows when len=N/2).
  always_comb begin
    j_d     = j_q;
    j2_d    = j2_q;
    start_d = start_q;
    len_d   = len_q;
    k_d     = k_q;
    stage_d = stage_q;
`ifdef NTT_STAGE_CTRL_INTT_EN
    inv_d   = inv_q;
`endif
    if (init_i) begin
      j_d     = '0;
      start_d = '0;
      stage_d = '0;
      len_d   = ADDR_W'(N / 2);
      k_d     = ONE;
`ifdef NTT_STAGE_CTRL_INTT_EN
      inv_d = inv_i;
      if (inv_i) begin
        len_d = ONE;
        k_d   = LAST_IDX;
      end
`endif
      j2_d = len_d;
    end else if (step_i) begin
      if (last_in_group) begin
        start_d = j_q + len_q + ONE;
        j_d     = start_d;
`ifdef NTT_STAGE_CTRL_INTT_EN
        k_d     = inv_q ? (k_q - ONE) : (k_q + ONE);
`else
        k_d     = k_q + ONE;
`endif
      end else begin
        j_d = j_q + ONE;
      end
      j2_d = j_d + len_q;
    end else if (next_stage_i) begin
      j_d     = '0;
      start_d = '0;
      stage_d = stage_q + ONE;
`ifdef NTT_STAGE_CTRL_INTT_EN
      len_d   = inv_q ? (len_q << 1) : (len_q >> 1);
`else
      len_d   = len_q >> 1;
`endif
      j2_d = len_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      j_q     <= '0;
      j2_q    <= '0;
      start_q <= '0;
      len_q   <= '0;
      k_q     <= '0;
      stage_q <= '0;
`ifdef NTT_STAGE_CTRL_INTT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      j_q     <= j_d;
      j2_q    <= j2_d;
      start_q <= start_d;
      len_q   <= len_d;
      k_q     <= k_d;
      stage_q <= stage_d;
`ifdef NTT_STAGE_CTRL_INTT_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT butterfly sequencer: FSM plus write-back address delay line.
// Optional inverse (Gentleman-Sande) schedule via NTT_STAGE_CTRL_INTT_EN.
module ntt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int BU_LAT = BU_LAT_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  ntt_stage_ctrl_if.slave bus
);
  localparam int LOG_N  = $clog2(N);
  localparam int ADDR_W = LOG_N;
  localparam int CNT_W  = $clog2(BU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BU_LAT - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init, step, next_stage;
  logic [ADDR_W-1:0] ag_j, ag_j2, ag_k;
  logic              ag_last_in_stage, ag_last_stage;

  logic [BU_LAT-1:0] wr_en_pipe_q, wr_en_pipe_d;
  logic [ADDR_W-1:0] wr_a1_pipe_q [BU_LAT];
  logic [ADDR_W-1:0] wr_a1_pipe_d [BU_LAT];
  logic [ADDR_W-1:0] wr_a2_pipe_q [BU_LAT];
  logic [ADDR_W-1:0] wr_a2_pipe_d [BU_LAT];

`ifdef NTT_STAGE_CTRL_INTT_EN
  logic tw_neg_q, tw_neg_d, ag_inv;
`endif

  ntt_addr_gen #(.N(N), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .init_i          (init),
`ifdef NTT_STAGE_CTRL_INTT_EN
    .inv_i           (bus.mode_i),
    .inv_o           (ag_inv),
`endif
    .step_i          (step),
    .next_stage_i    (next_stage),
    .j_o             (ag_j),
    .j2_o            (ag_j2),
    .k_o             (ag_k),
    .last_in_stage_o (ag_last_in_stage),
    .last_stage_o    (ag_last_stage)
  );

  // DRAIN holds reads off for BU_LAT cycles so the next stage never reads a stale word.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    cnt_d      = cnt_q;
    init       = 1'b0;
    step       = 1'b0;
    next_stage = 1'b0;
`ifdef NTT_STAGE_CTRL_INTT_EN
    tw_neg_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          init    = 1'b1;
`ifdef NTT_STAGE_CTRL_INTT_EN
          tw_neg_d = bus.mode_i;
`endif
        end
      end
      ISSUE: begin
        step  = 1'b1;
        cnt_d = '0;
        if (ag_last_in_stage) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
`ifdef NTT_STAGE_CTRL_INTT_EN
          tw_neg_d = ag_inv;
`endif
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (ag_last_stage) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = ISSUE;
            rd_en_d    = 1'b1;
            next_stage = 1'b1;
`ifdef NTT_STAGE_CTRL_INTT_EN
            tw_neg_d = ag_inv;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_pipe_d[0] = rd_en_q;
    wr_a1_pipe_d[0] = ag_j;
    wr_a2_pipe_d[0] = ag_j2;
    for (int i = 1; i < BU_LAT; i++) begin
      wr_en_pipe_d[i] = wr_en_pipe_q[i-1];
      wr_a1_pipe_d[i] = wr_a1_pipe_q[i-1];
      wr_a2_pipe_d[i] = wr_a2_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      cnt_q        <= '0;
      wr_en_pipe_q <= '0;
      for (int i = 0; i < BU_LAT; i++) begin
        wr_a1_pipe_q[i] <= '0;
        wr_a2_pipe_q[i] <= '0;
      end
`ifdef NTT_STAGE_CTRL_INTT_EN
      tw_neg_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      cnt_q        <= cnt_d;
      wr_en_pipe_q <= wr_en_pipe_d;
      wr_a1_pipe_q <= wr_a1_pipe_d;
      wr_a2_pipe_q <= wr_a2_pipe_d;
`ifdef NTT_STAGE_CTRL_INTT_EN
      tw_neg_q     <= tw_neg_d;
`endif
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.rd_en_o    = rd_en_q;
  assign bus.rd_addr1_o = ag_j;
  assign bus.rd_addr2_o = ag_j2;
  assign bus.tw_addr_o  = ag_k;
  assign bus.wr_en_o    = wr_en_pipe_q[BU_LAT-1];
  assign bus.wr_addr1_o = wr_a1_pipe_q[BU_LAT-1];
  assign bus.wr_addr2_o = wr_a2_pipe_q[BU_LAT-1];
`ifdef NTT_STAGE_CTRL_INTT_EN
  assign bus.tw_neg_o   = tw_neg_q;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: random start/reset disturbances checked against a
// loop-level model of the NTT issue schedule (inverse runs with NTT_STAGE_CTRL_INTT_EN).
module tb_ntt_stage_ctrl;
  import ntt_pkg::*;

  localparam int N         = N_DEF;
  localparam int BU_LAT    = BU_LAT_DEF;
  localparam int LOG_N     = $clog2(N);
  localparam int ADDR_W    = $clog2(N);
  localparam int HALF      = N / 2;
  localparam int STAGE_CYC = HALF + BU_LAT;
  localparam int DONE_CYC  = 1 + LOG_N * STAGE_CYC;
  localparam int TOTAL     = HALF * LOG_N;

  logic clk = 1'b0;
  logic rst;
  logic invSel;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   expA1 [TOTAL];
  int   expA2 [TOTAL];
  int   expK  [TOTAL];

  ntt_stage_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ntt_stage_ctrl #(.N(N), .BU_LAT(BU_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 20000);
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic reset);
    bus.start_i = start;
    rst         = reset;
`ifdef NTT_STAGE_CTRL_INTT_EN
    bus.mode_i  = invSel;
`endif
  endtask

  // Schedule straight from the butterfly loop nest: stage, group, index within group.
  task automatic buildModel(input logic inv);
    int len, k, n;
    n   = 0;
    len = inv ? 1 : HALF;
    k   = inv ? N - 1 : 1;
    for (int s = 0; s < LOG_N; s++) begin
      for (int st = 0; st < N; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          expA1[n] = j;
          expA2[n] = j + len;
          expK[n]  = k;
          n++;
        end
        k = inv ? k - 1 : k + 1;
      end
      len = inv ? len * 2 : len / 2;
    end
  endtask

  function automatic int issueAt(input int cyc);
    int c;
    if (cyc < 1) return -1;
    c = cyc - 1;
    if (c >= LOG_N * STAGE_CYC) return -1;
    if ((c % STAGE_CYC) >= HALF) return -1;
    return (c / STAGE_CYC) * HALF + (c % STAGE_CYC);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  32'(bus.busy_o),     0);
    checkOutput({tag, "_done"},  32'(bus.done_o),     0);
    checkOutput({tag, "_rd_en"}, 32'(bus.rd_en_o),    0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en_o),    0);
    checkOutput({tag, "_rd_a1"}, 32'(bus.rd_addr1_o), 0);
    checkOutput({tag, "_rd_a2"}, 32'(bus.rd_addr2_o), 0);
    checkOutput({tag, "_tw"},    32'(bus.tw_addr_o),  0);
    checkOutput({tag, "_wr_a1"}, 32'(bus.wr_addr1_o), 0);
    checkOutput({tag, "_wr_a2"}, 32'(bus.wr_addr2_o), 0);
`ifdef NTT_STAGE_CTRL_INTT_EN
    checkOutput({tag, "_tw_neg"}, 32'(bus.tw_neg_o),  0);
`endif
  endtask

  // Called at a negedge with the DUT idle; that cycle is cycle 0 (start sampled).
  task automatic runTransform(input int abortAt);
    int   rdCount, wrCount, idx, widx;
    logic rdExp, wrExp, noise;
    buildModel(invSel);
    checkOutput("c0_busy",  32'(bus.busy_o),  0);
    checkOutput("c0_rd_en", 32'(bus.rd_en_o), 0);
    applyStimulus(1'b1, 1'b0);
    rdCount = 0;
    wrCount = 0;
    for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
      @(negedge clk);
      idx   = issueAt(cyc);
      widx  = issueAt(cyc - BU_LAT);
      rdExp = (idx >= 0);
      wrExp = (widx >= 0);
      checkOutput($sformatf("rd_en@%0d", cyc), 32'(bus.rd_en_o), 32'(rdExp));
      checkOutput($sformatf("wr_en@%0d", cyc), 32'(bus.wr_en_o), 32'(wrExp));
      checkOutput($sformatf("busy@%0d", cyc),  32'(bus.busy_o),  32'(cyc < DONE_CYC));
      checkOutput($sformatf("done@%0d", cyc),  32'(bus.done_o),  32'(cyc == DONE_CYC));
      if (rdExp) begin
        checkOutput($sformatf("rd_a1@%0d", cyc), 32'(bus.rd_addr1_o), expA1[idx]);
        checkOutput($sformatf("rd_a2@%0d", cyc), 32'(bus.rd_addr2_o), expA2[idx]);
        checkOutput($sformatf("tw@%0d", cyc),    32'(bus.tw_addr_o),  expK[idx]);
`ifdef NTT_STAGE_CTRL_INTT_EN
        checkOutput($sformatf("tw_neg@%0d", cyc), 32'(bus.tw_neg_o), 32'(invSel));
`endif
      end
      if (wrExp) begin
        checkOutput($sformatf("wr_a1@%0d", cyc), 32'(bus.wr_addr1_o), expA1[widx]);
        checkOutput($sformatf("wr_a2@%0d", cyc), 32'(bus.wr_addr2_o), expA2[widx]);
      end
      if (bus.rd_en_o === 1'b1) rdCount++;
      if (bus.wr_en_o === 1'b1) wrCount++;
      if (cyc == abortAt) begin
        applyStimulus(1'($urandom_range(1)), 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkAllZero($sformatf("abort@%0d", cyc));
        for (int i = 0; i < BU_LAT + 4; i++) begin
          @(negedge clk);
          checkOutput($sformatf("abort_wr_en+%0d", i), 32'(bus.wr_en_o), 0);
          checkOutput($sformatf("abort_rd_en+%0d", i), 32'(bus.rd_en_o), 0);
          checkOutput($sformatf("abort_busy+%0d", i),  32'(bus.busy_o),  0);
        end
        return;
      end
      noise = (cyc == 5) || (cyc == 300) || (cyc == DONE_CYC) || ($urandom_range(3) == 0);
      applyStimulus(noise, 1'b0);
`ifdef NTT_STAGE_CTRL_INTT_EN
      bus.mode_i = 1'($urandom_range(1));
`endif
    end
    checkOutput("rd_count", rdCount, TOTAL);
    checkOutput("wr_count", wrCount, TOTAL);
  endtask

  initial begin
    $display("[TB] ntt_stage_ctrl bench N=%0d BU_LAT=%0d done expected at cycle %0d",
             N, BU_LAT, DONE_CYC);
    invSel = 1'b0;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    checkAllZero("idle");

    runTransform(-1);
    @(negedge clk);
`ifdef NTT_STAGE_CTRL_INTT_EN
    invSel = 1'b1;
`endif
    runTransform(-1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat ($urandom_range(1, 5)) @(negedge clk);

    invSel = 1'b0;
    runTransform(400);
`ifdef NTT_STAGE_CTRL_INTT_EN
    invSel = 1'($urandom_range(1));
`endif
    runTransform($urandom_range(2, DONE_CYC - 1));
    invSel = 1'b0;
    runTransform(-1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("final_busy", 32'(bus.busy_o), 0);
    checkOutput("final_done", 32'(bus.done_o), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for the combinational NTT butterfly datapath: runs a full in-place N-point Cooley-Tukey forward NTT over a dual-port coefficient RAM.
- Each cycle it issues one butterfly: two coefficient read addresses plus the twiddle ROM index.
- It delays the addresses through a BU_LAT-deep pipeline so the results are written back to the same locations.
- Sits between the top-level command interface (start/done) and the coefficient RAM, twiddle ROM and butterfly/reduction pipeline.

Parameters:
- N, 256, transform length; power of two, at least 4.
- LOG_N, $clog2(N), number of stages; derived, not overridden.
- ADDR_W, $clog2(N), width of coefficient and twiddle addresses.
- BU_LAT, 3, cycles from rd_en_o to the matching wr_en_o (RAM read + butterfly + modular reduction); at least 1.

Ports:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a transform; sampled only in IDLE.
- busy_o  out  1  high from the first ISSUE cycle through the last DRAIN cycle.
- done_o  out  1  one-cycle pulse when the final write-back has completed.
- rd_en_o  out  1  butterfly issue strobe to the coefficient RAM.
- rd_addr1_o  out  ADDR_W  index j (upper butterfly input).
- rd_addr2_o  out  ADDR_W  index j+len (lower butterfly input).
- tw_addr_o  out  ADDR_W  twiddle ROM index k.
- wr_en_o  out  1  write-back strobe; equals rd_en_o delayed BU_LAT cycles.
- wr_addr1_o  out  ADDR_W  rd_addr1_o delayed BU_LAT cycles.
- wr_addr2_o  out  ADDR_W  rd_addr2_o delayed BU_LAT cycles.

Behaviour:
- Reset values: busy_o=0, done_o=0, rd_en_o=0, wr_en_o=0, all addresses 0. The state machine goes to IDLE and the write pipeline valid bits clear.
- Reset mid-transform: all activity aborts in the same edge; no further wr_en_o pulses.
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE: start_i=1 moves to ISSUE. Loop state initialises to len=N/2, start=0, j=0, k=1, stage=0.
- ISSUE: one butterfly per cycle with rd_en_o=1, rd_addr1_o=j, rd_addr2_o=j+len, tw_addr_o=k.
- Inner index: j increments.
- Group end (j==start+len-1): start becomes start+2*len, j becomes that new start, and k increments.
- Stage end (last group, j==N-len-1): go to DRAIN. Exactly N/2 issues per stage.
- DRAIN: rd_en_o=0 for exactly BU_LAT cycles; the last write of the stage occurs in the final DRAIN cycle.
  - If stage<LOG_N-1: len halves, start=0, j=0, stage increments, k keeps counting; next state ISSUE.
  - Otherwise: next state DONE.
  - DRAIN prevents stage s+1 from reading locations still being written by stage s. The RAM is required to return write data on a read in the following cycle.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- Twiddle indices: k runs 1..N-1 across the whole transform and never wraps inside a transform.
- Handshake rules:
  - start_i outside IDLE is ignored, with no queuing.
  - start_i asserted in the DONE cycle is ignored.
  - start_i held high in IDLE after DONE starts a new transform.
- Timing with start_i sampled in cycle 0:
  - ISSUE begins in cycle 1.
  - Each stage lasts N/2+BU_LAT cycles.
  - done_o is high in cycle 1+LOG_N*(N/2+BU_LAT), which is 1049 for the defaults.
- Address arithmetic is ADDR_W bits and never overflows, since j+len<N always.

Optional Feature:
- Macro: NTT_STAGE_CTRL_INTT_EN.
- When defined:
  - Add input mode_i (1 bit, sampled with start_i): 0 = forward, 1 = inverse Gentleman-Sande.
  - Add output tw_neg_o, high during inverse ISSUE cycles; the datapath negates the twiddle.
  - Inverse schedule: len starts at 1 and doubles each stage; k starts at N-1 and decrements at each group end. The address pattern within a stage is unchanged.
  - The inverse final-scaling pass is not part of this block.
- When undefined: forward only. mode_i and tw_neg_o are absent, and the logic is identical to the forward path.

Decomposition:
- Package ntt_pkg holds:
  - the state enum type (IDLE, ISSUE, DRAIN, DONE);
  - constants N_DEF=256, Q=8380417, BU_LAT_DEF=3;
  - an addr_t typedef.
- Sub-module ntt_addr_gen holds the j/start/len/k/stage counters with next-butterfly, last-in-group and last-in-stage flags. The top level holds the FSM and the delay pipeline.

Test Plan:
- Reset, then start_i pulse: cycle 1 gives rd_addr1/2=0/128, tw=1.
- Cycle 128 gives 127/255, tw=1, then BU_LAT DRAIN cycles with rd_en_o=0.
- Stage 1: first issues 0/64 tw=2; the group starting at 128 issues 128/192 tw=3. Stage 7 issues pairs (2i, 2i+1) with tw=128+i; the final pair is 254/255 with tw=255.
- Over the full run: exactly 1024 rd_en_o and 1024 wr_en_o pulses, and every wr_addr equals the rd_addr from BU_LAT cycles earlier.
- done_o is a single pulse at cycle 1049 and busy_o is high for cycles 1..1048. Changing BU_LAT to 1 moves done_o to cycle 1033.
- start_i asserted at cycles 5, 300 and 1049 is ignored, with no schedule perturbation.
- rst_i asserted at cycle 400: outputs are at reset values next cycle, with no wr_en_o afterwards. A new start_i gives the first issue 0/128 tw=1.
- With NTT_STAGE_CTRL_INTT_EN and mode_i=1: the first issue is 0/1 tw=255 with tw_neg_o=1. The last issue is 127/255 tw=1, and done_o is still at cycle 1049.
